// File: rtl/eth_rx_frame_fifo.sv
// Store-and-forward RX frame FIFO behind a 1G MAC (no tready on input).
// Ports: rx_clk/rx_rst_n; s_axis_* MAC input; m_axis_* buffered output;
// status_* one-cycle pulses; good/drop frame counters.
module eth_rx_frame_fifo #(
  parameter int DEPTH          = 4096,
  parameter bit DROP_BAD_FRAME = 1'b1
) (
  input  logic        rx_clk,
  input  logic        rx_rst_n,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  input  logic        s_axis_tlast,
  input  logic        s_axis_tuser,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser,
  output logic        status_good_frame,
  output logic        status_bad_frame,
  output logic        status_overflow,
  output logic [31:0] good_frame_count,
  output logic [31:0] drop_frame_count
);

  localparam int AW = $clog2(DEPTH);

  logic [9:0]  mem [DEPTH];
  logic [AW:0] wr_ptr_cur;
  logic [AW:0] wr_ptr_commit;
  logic [AW:0] rd_ptr;
  logic        drop;

  logic [AW:0] occupancy;
  logic        full;
  logic        wr_en;
  logic        ovf_end;
  logic        bad_end;
  logic        good_end;
  logic        rd_en;
  logic        wr_user;

  // Full uses the registered rd_ptr: a read this cycle frees
  // space only from the next cycle on.
  assign occupancy = wr_ptr_cur - rd_ptr;
  assign full      = (occupancy == (AW+1)'(DEPTH));

  // tuser is only meaningful on the tlast beat.
  assign wr_user = DROP_BAD_FRAME ? 1'b0
                 : (s_axis_tlast & s_axis_tuser);

  always_comb begin
    wr_en    = 1'b0;
    ovf_end  = 1'b0;
    bad_end  = 1'b0;
    good_end = 1'b0;
    if (s_axis_tvalid) begin
      if (s_axis_tlast) begin
        if (drop || full) begin
          ovf_end = 1'b1;
        end else if (s_axis_tuser && DROP_BAD_FRAME) begin
          bad_end = 1'b1;
        end else begin
          good_end = 1'b1;
          wr_en    = 1'b1;
        end
      end else if (!drop && !full) begin
        wr_en = 1'b1;
      end
    end
  end

  always_ff @(posedge rx_clk) begin
    if (wr_en && rx_rst_n) begin
      mem[wr_ptr_cur[AW-1:0]] <=
        {wr_user, s_axis_tlast, s_axis_tdata};
    end
  end

  always_ff @(posedge rx_clk) begin
    if (!rx_rst_n) begin
      wr_ptr_cur        <= '0;
      wr_ptr_commit     <= '0;
      drop              <= 1'b0;
      status_good_frame <= 1'b0;
      status_bad_frame  <= 1'b0;
      status_overflow   <= 1'b0;
      good_frame_count  <= '0;
      drop_frame_count  <= '0;
    end else begin
      status_good_frame <= good_end;
      status_bad_frame  <= bad_end;
      status_overflow   <= ovf_end;
      if (wr_en) begin
        wr_ptr_cur <= wr_ptr_cur + 1'b1;
      end
      if (good_end) begin
        wr_ptr_commit <= wr_ptr_cur + 1'b1;
      end
      // Rewind discards every byte of the current frame.
      if (ovf_end || bad_end) begin
        wr_ptr_cur <= wr_ptr_commit;
      end
      if (s_axis_tvalid) begin
        drop <= s_axis_tlast ? 1'b0 : (drop | full);
      end
      if (good_end) begin
        good_frame_count <= good_frame_count + 32'd1;
      end
      if (ovf_end || bad_end) begin
        drop_frame_count <= drop_frame_count + 32'd1;
      end
    end
  end

  assign rd_en = (rd_ptr != wr_ptr_commit) &&
                 (!m_axis_tvalid || m_axis_tready);

  always_ff @(posedge rx_clk) begin
    if (!rx_rst_n) begin
      rd_ptr        <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
    end else if (rd_en) begin
      {m_axis_tuser, m_axis_tlast, m_axis_tdata} <=
        mem[rd_ptr[AW-1:0]];
      m_axis_tvalid <= 1'b1;
      rd_ptr        <= rd_ptr + 1'b1;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

endmodule

// File: doc/eth_rx_frame_fifo.md
Name: eth_rx_frame_fifo

Overview:
Store-and-forward receive FIFO placed directly downstream of the 1G MAC receive AXI-Stream output. The MAC output has no tready. This block buffers each frame and forwards it on a backpressurable AXI-Stream master only after the frame completes with a good status. Frames marked bad (tuser=1) and frames that overflow the buffer are discarded entirely. Single clock: the MAC rx_clk domain.

Parameters:
DEPTH, 4096, buffer capacity in bytes; power of two, minimum 16.
DROP_BAD_FRAME, 1, 1 = discard frames ending with tuser=1; 0 = forward them with m_axis_tuser=1.

Ports:
rx_clk  input  1  clock, MAC receive clock
rx_rst_n  input  1  synchronous active-low reset
s_axis_tdata  input  8  MAC receive data
s_axis_tvalid  input  1  MAC receive valid; no ready, a beat is taken every cycle it is high
s_axis_tlast  input  1  last byte of frame
s_axis_tuser  input  1  bad-frame flag, meaningful on tlast beat only
m_axis_tdata  output  8  buffered frame data
m_axis_tvalid  output  1  output valid
m_axis_tready  input  1  output ready
m_axis_tlast  output  1  last byte of frame
m_axis_tuser  output  1  bad flag; always 0 when DROP_BAD_FRAME=1
status_good_frame  output  1  one-cycle pulse when a frame is committed
status_bad_frame  output  1  one-cycle pulse when a frame is dropped for tuser
status_overflow  output  1  one-cycle pulse when a frame is dropped for overflow
good_frame_count  output  32  committed frames, wraps at 2^32
drop_frame_count  output  32  dropped frames (bad plus overflow), wraps at 2^32

Behaviour:
- Storage: DEPTH x 10-bit RAM holding {tuser, tlast, tdata}. Pointers are log2(DEPTH)+1 bits: wr_ptr_cur, wr_ptr_commit, rd_ptr.
- Occupancy = wr_ptr_cur - rd_ptr, modulo arithmetic. Full when occupancy == DEPTH. A frame of exactly DEPTH bytes fits in an empty FIFO.
- Write, per s_axis beat:
  - If not dropping and not full: write at wr_ptr_cur and increment wr_ptr_cur.
  - If full on a beat: enter drop mode for the rest of that frame. No further writes; beats are ignored until tlast.
- On the tlast beat, exactly one of the following happens (priority in this order):
  - overflow (drop mode, or full on this beat): wr_ptr_cur <= wr_ptr_commit; pulse status_overflow.
  - tuser=1 and DROP_BAD_FRAME=1: wr_ptr_cur <= wr_ptr_commit; pulse status_bad_frame.
  - otherwise: the byte is written and wr_ptr_commit <= wr_ptr_cur+1; pulse status_good_frame.
- Drop mode clears after the tlast beat. A new frame starting the next cycle is handled normally.
- Counters: good_frame_count increments on status_good_frame. drop_frame_count increments on status_bad_frame or status_overflow.
- Read side:
  - A RAM read is issued when rd_ptr != wr_ptr_commit and the output register is empty or being consumed (m_axis_tvalid & m_axis_tready) in the same cycle.
  - Read latency is one cycle into the output register; sustained throughput is 1 byte/cycle.
- Latency: tlast written in cycle N → commit visible in N+1 → m_axis_tvalid high in N+2 at the earliest.
- AXI-Stream rules:
  - m_axis_tvalid, once high, stays high with stable data until m_axis_tready.
  - Only committed bytes are ever presented; no partial frame ever appears on the master.
- Reads and writes in the same cycle are both allowed. The rd_ptr advance in a cycle is counted for the full check of the next cycle, not the current one.
- Reset (rx_rst_n=0 at a clock edge):
  - All pointers = 0, drop mode = 0, output register empty.
  - m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, m_axis_tuser=0.
  - All status pulses 0; both counters 0.
  - A frame in progress during reset is lost. Input beats are ignored while reset is low. If reset deasserts mid-frame, the remaining beats are stored as a new frame.

Test Plan:
- DEPTH=16, 10-byte good frame (0x00..0x09, tuser=0), m_axis_tready=1 → identical 10 bytes out, tlast on 0x09; first tvalid 2 cycles after input tlast; status_good_frame pulses once; good_frame_count=1.
- 8-byte frame ending tuser=1, then 5-byte good frame → only the 5-byte frame emerges; drop_frame_count=1, good_frame_count=1, status_bad_frame pulses once.
- DEPTH=16, m_axis_tready=0, frames of 16 then 17 bytes → first fits and commits; second gives status_overflow; after tready=1 exactly 16 bytes out, then tvalid stays 0.
- Backpressure: 64-byte frame, DEPTH=4096, tready toggled randomly → byte order preserved, tdata stable while tvalid=1 & tready=0, one tlast.
- Pointer wrap: DEPTH=16, 50 back-to-back 7-byte frames with tready=1 → all 350 bytes out in order, zero drops, good_frame_count=50.
- Reset asserted after byte 3 of a 10-byte frame, with a previous committed frame partially read → after release m_axis_tvalid=0, counters=0; next full frame is forwarded intact.
